// File: rtl/gumnut_port_responder_pkg.sv
// Shared register offsets, CTRL bit positions and bus FSM encoding for the Gumnut port responder.
// Pure declarations: no latency and no flow control.
package gumnut_port_pkg;

  localparam logic [1:0] REG_OUT    = 2'd0;
  localparam logic [1:0] REG_IN     = 2'd1;
  localparam logic [1:0] REG_RELOAD = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int CTRL_TMR_EN  = 0;
  localparam int CTRL_INT_EN  = 1;
  localparam int CTRL_PENDING = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } bus_state_e;

  function automatic logic [7:0] ctrl_pack(logic tmr_en, logic int_en, logic pending);
    logic [7:0] v;
    v = 8'h00;
    v[CTRL_TMR_EN]  = tmr_en;
    v[CTRL_INT_EN]  = int_en;
    v[CTRL_PENDING] = pending;
    return v;
  endfunction

endpackage

// File: rtl/gumnut_port_responder_if.sv
// Gumnut port bus between the core (master) and a responder (slave).
// The master holds cyc/stb/we/adr/wr_dat until ack; there is no other backpressure.
interface gumnut_port_responder_if;
  logic       cyc;
  logic       stb;
  logic       we;
  logic [7:0] adr;
  logic [7:0] wr_dat;
  logic       ack;
  logic [7:0] rd_dat;

  modport master (output cyc, stb, we, adr, wr_dat, input  ack, rd_dat);
  modport slave  (input  cyc, stb, we, adr, wr_dat, output ack, rd_dat);
endinterface

// File: rtl/gumnut_port_responder_timer.sv
// Prescaled 8-bit down-counter that sets a pending flag on expiry; one tick per PRESCALE enabled cycles.
// No backpressure: load/clr/int_ack act on the next edge, and a timer set beats any clear.
module gumnut_port_timer #(
  parameter int PRESCALE = 100
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tmr_en,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic [7:0] reload,
  input  logic       clr,
  input  logic       int_ack,
  output logic       pending,
  output logic       pending_nxt
);

  localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;
  logic [7:0]    cnt_q;
  logic          pending_q;
  logic          tick;
  logic          fire;

  assign tick = tmr_en & (pre_q == PRE_MAX);
  // A reload write overrides the tick completely, so it can never also raise pending.
  assign fire        = tick & ~load & (cnt_q == 8'h00);
  assign pending_nxt = fire | (pending_q & ~clr & ~int_ack);
  assign pending     = pending_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q     <= '0;
      cnt_q     <= 8'hFF;
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_nxt;
      if (load || !tmr_en || tick) begin
        pre_q <= '0;
      end else begin
        pre_q <= pre_q + PW'(1);
      end
      if (load) begin
        cnt_q <= load_val;
      end else if (tick) begin
        cnt_q <= (cnt_q == 8'h00) ? reload : cnt_q - 8'd1;
      end
    end
  end

endmodule

// File: rtl/gumnut_port_responder.sv
// Gumnut port responder: GPIO out/in, timer reload and CTRL/status at BASE_ADDR..BASE_ADDR+3.
// Ack is registered 1+WAIT_STATES cycles after select; unmapped requests are never acked.
module gumnut_port_responder
  import gumnut_port_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR   = 8'h10,
  parameter int         WAIT_STATES = 0,
  parameter int         PRESCALE    = 100
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  gumnut_port_responder_if.slave  port,
  output logic [7:0]              gpio_o,
  input  logic [7:0]              gpio_i,
  output logic                    int_req_o,
  input  logic                    int_ack_i
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  bus_state_e state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic       cyc_stb, sel;

  logic       req_we_q;
  logic [1:0] req_off_q;
  logic [7:0] req_dat_q;

  logic       ack_d, commit;
  logic       wr_out, wr_reload, wr_ctrl, ctrl_clr, int_en_d;
  logic [7:0] rd_mux, rd_dat_d;

  logic [7:0] gpio_q, reload_q, sync1_q, sync2_q, rd_dat_q;
  logic       tmr_en_q, int_en_q, ack_q, int_req_q;
  logic       pending, pending_nxt;

  assign cyc_stb = port.cyc & port.stb;
  assign sel     = cyc_stb & (port.adr[7:2] == BASE_ADDR[7:2]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (sel) begin
          if (WS == 4'd0) begin
            state_d = ACK;
          end else begin
            state_d = WAIT;
            wcnt_d  = WS;
          end
        end
      end
      WAIT: begin
        if (!sel) begin
          state_d = IDLE;
        end else if (wcnt_q == 4'd1) begin
          state_d = ACK;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ACK:  state_d = HOLD;
      // Hold until the master releases the strobe so one request yields one ack.
      HOLD: if (!cyc_stb) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_d     = (state_d == ACK);
    commit    = (state_q == ACK) & req_we_q;
    wr_out    = commit & (req_off_q == REG_OUT);
    wr_reload = commit & (req_off_q == REG_RELOAD);
    wr_ctrl   = commit & (req_off_q == REG_CTRL);
    // A CTRL write with bit7 set is a pure pending clear and leaves the enables alone.
    ctrl_clr  = wr_ctrl & req_dat_q[CTRL_PENDING];
    int_en_d  = (wr_ctrl && !req_dat_q[CTRL_PENDING]) ? req_dat_q[CTRL_INT_EN] : int_en_q;
    case (port.adr[1:0])
      REG_OUT:    rd_mux = gpio_q;
      REG_IN:     rd_mux = sync2_q;
      REG_RELOAD: rd_mux = reload_q;
      default:    rd_mux = ctrl_pack(tmr_en_q, int_en_q, pending);
    endcase
    rd_dat_d = ack_d ? rd_mux : 8'h00;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_we_q  <= 1'b0;
      req_off_q <= '0;
      req_dat_q <= '0;
      ack_q     <= 1'b0;
      rd_dat_q  <= '0;
      gpio_q    <= '0;
      reload_q  <= 8'hFF;
      tmr_en_q  <= 1'b0;
      int_en_q  <= 1'b0;
      int_req_q <= 1'b0;
      sync1_q   <= '0;
      sync2_q   <= '0;
    end else begin
      // Capture the request while it is pending so the commit does not depend on bus timing in ACK.
      if (state_q == IDLE || state_q == WAIT) begin
        req_we_q  <= port.we;
        req_off_q <= port.adr[1:0];
        req_dat_q <= port.wr_dat;
      end
      ack_q     <= ack_d;
      rd_dat_q  <= rd_dat_d;
      sync1_q   <= gpio_i;
      sync2_q   <= sync1_q;
      int_en_q  <= int_en_d;
      int_req_q <= pending_nxt & int_en_d;
      if (wr_out)    gpio_q   <= req_dat_q;
      if (wr_reload) reload_q <= req_dat_q;
      if (wr_ctrl && !req_dat_q[CTRL_PENDING]) tmr_en_q <= req_dat_q[CTRL_TMR_EN];
    end
  end

  gumnut_port_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .tmr_en      (tmr_en_q),
    .load        (wr_reload),
    .load_val    (req_dat_q),
    .reload      (reload_q),
    .clr         (ctrl_clr),
    .int_ack     (int_ack_i),
    .pending     (pending),
    .pending_nxt (pending_nxt)
  );

  assign port.ack    = ack_q;
  assign port.rd_dat = rd_dat_q;
  assign gpio_o      = gpio_q;
  assign int_req_o   = int_req_q;

endmodule

// File: tb/tb_gumnut_port_responder.sv
// Self-checking bench for gumnut_port_responder: vector table, directed corner cases, random model run.
module tb_gumnut_port_responder;

  localparam int WS  = 2;
  localparam int PRE = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] gpio_o, gpio_i;
  logic       int_req, int_ack;

  gumnut_port_responder_if port_if ();

  gumnut_port_responder #(
    .BASE_ADDR   (8'h10),
    .WAIT_STATES (WS),
    .PRESCALE    (PRE)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .port      (port_if),
    .gpio_o    (gpio_o),
    .gpio_i    (gpio_i),
    .int_req_o (int_req),
    .int_ack_i (int_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  int rd_leak = 0;
  int last_ack_cyc = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    bit         we;
    logic [7:0] adr;
    logic [7:0] wdat;
    logic [7:0] exp_rd;
    logic [7:0] exp_gpio;
  } vec_t;

  vec_t tbl[11];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int t);
    if (cyc_cnt > t) check("schedule", 32'(cyc_cnt), 32'(t));
    for (int g = 0; g < 1000 && cyc_cnt < t; g++) step();
  endtask

  task automatic req_start(bit we, logic [7:0] adr, logic [7:0] dat);
    port_if.cyc    = 1'b1;
    port_if.stb    = 1'b1;
    port_if.we     = we;
    port_if.adr    = adr;
    port_if.wr_dat = dat;
  endtask

  task automatic wait_ack(output int lat, output logic [7:0] rdat, output bit got);
    got  = 1'b0;
    lat  = 0;
    rdat = 8'h00;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (port_if.ack === 1'b1) begin
        got          = 1'b1;
        lat          = i;
        rdat         = port_if.rd_dat;
        last_ack_cyc = cyc_cnt;
        break;
      end else if (port_if.rd_dat !== 8'h00) begin
        rd_leak++;
      end
    end
  endtask

  task automatic bus_xfer(bit we, logic [7:0] adr, logic [7:0] dat,
                          output logic [7:0] rdat, output int lat);
    bit got;
    req_start(we, adr, dat);
    wait_ack(lat, rdat, got);
    port_if.cyc = 1'b0;
    port_if.stb = 1'b0;
    if (!got) check("ack_timeout", 32'(0), 32'(1));
    step();
    check("ack_width", {23'd0, port_if.ack, port_if.rd_dat}, 32'(0));
    step();
  endtask

  task automatic count_acks(int n, output int acks);
    acks = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (port_if.ack !== 1'b0) acks++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd, m_out, m_reload, m_in, d;
    int lat, acks, t_ctrl, r_cyc;
    bit got;

    tbl[0]  = '{1'b1, 8'h10, 8'hA5, 8'h00, 8'hA5};
    tbl[1]  = '{1'b0, 8'h10, 8'h00, 8'hA5, 8'hA5};
    tbl[2]  = '{1'b0, 8'h11, 8'h00, 8'h3C, 8'hA5};
    tbl[3]  = '{1'b1, 8'h11, 8'hFF, 8'h00, 8'hA5};
    tbl[4]  = '{1'b0, 8'h11, 8'h00, 8'h3C, 8'hA5};
    tbl[5]  = '{1'b0, 8'h12, 8'h00, 8'hFF, 8'hA5};
    tbl[6]  = '{1'b0, 8'h13, 8'h00, 8'h00, 8'hA5};
    tbl[7]  = '{1'b1, 8'h12, 8'h07, 8'h00, 8'hA5};
    tbl[8]  = '{1'b0, 8'h12, 8'h00, 8'h07, 8'hA5};
    tbl[9]  = '{1'b1, 8'h10, 8'h5A, 8'h00, 8'h5A};
    tbl[10] = '{1'b0, 8'h10, 8'h00, 8'h5A, 8'h5A};

    port_if.cyc = 1'b0; port_if.stb = 1'b0; port_if.we = 1'b0;
    port_if.adr = 8'h00; port_if.wr_dat = 8'h00;
    int_ack = 1'b0;
    gpio_i  = 8'h3C;
    rst_n   = 1'b0;
    step(); step();
    check("rst_ack",     32'(port_if.ack),    32'(0));
    check("rst_rd_dat",  32'(port_if.rd_dat), 32'(0));
    check("rst_gpio",    32'(gpio_o),         32'(0));
    check("rst_int_req", 32'(int_req),        32'(0));
    rst_n = 1'b1;
    step(); step(); step();

    for (int i = 0; i < 11; i++) begin
      bus_xfer(tbl[i].we, tbl[i].adr, tbl[i].wdat, rd, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(WS + 1));
      if (!tbl[i].we) check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(tbl[i].exp_rd));
      check($sformatf("vec%0d_gpio", i), 32'(gpio_o), 32'(tbl[i].exp_gpio));
    end

    // gpio_i change one cycle into a read must not reach the read data yet
    req_start(1'b0, 8'h11, 8'h00);
    step();
    gpio_i = 8'hC3;
    wait_ack(lat, rd, got);
    port_if.cyc = 1'b0; port_if.stb = 1'b0;
    check("sync_not_early", 32'(rd), 32'(8'h3C));
    step(); step();
    bus_xfer(1'b0, 8'h11, 8'h00, rd, lat);
    check("sync_settled", 32'(rd), 32'(8'hC3));

    // select dropped during WAIT: no ack, FSM recovers
    req_start(1'b0, 8'h10, 8'h00);
    step();
    port_if.stb = 1'b0;
    count_acks(6, acks);
    check("drop_in_wait_no_ack", 32'(acks), 32'(0));
    port_if.cyc = 1'b0;
    bus_xfer(1'b0, 8'h10, 8'h00, rd, lat);
    check("after_drop_lat", 32'(lat), 32'(WS + 1));

    // unmapped addresses
    req_start(1'b1, 8'h20, 8'h00);
    count_acks(50, acks);
    check("unmapped_20_no_ack", 32'(acks), 32'(0));
    port_if.stb = 1'b0; port_if.cyc = 1'b0;
    step();
    req_start(1'b1, 8'h14, 8'h00);
    count_acks(10, acks);
    check("unmapped_14_no_ack", 32'(acks), 32'(0));
    port_if.stb = 1'b0; port_if.cyc = 1'b0;
    step();
    bus_xfer(1'b0, 8'h10, 8'h00, rd, lat);
    check("unmapped_out_kept", 32'(rd), 32'(8'h5A));
    check("unmapped_lat",      32'(lat), 32'(WS + 1));
    bus_xfer(1'b0, 8'h12, 8'h00, rd, lat);
    check("unmapped_reload_kept", 32'(rd), 32'(8'h07));

    // timer: RELOAD=2, enable timer+int, expiry every PRE*(2+1) cycles
    bus_xfer(1'b1, 8'h12, 8'h02, rd, lat);
    bus_xfer(1'b1, 8'h13, 8'h03, rd, lat);
    t_ctrl = last_ack_cyc;
    r_cyc  = -1;
    for (int i = 0; i < 100; i++) begin
      if (int_req === 1'b1) begin r_cyc = cyc_cnt; break; end
      step();
    end
    check("int_first_rise", 32'(r_cyc - t_ctrl), 32'(1 + PRE * 3));
    bus_xfer(1'b0, 8'h13, 8'h00, rd, lat);
    check("ctrl_pending_read", 32'(rd), 32'(8'h83));
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    check("int_ack_clears", 32'(int_req), 32'(0));
    wait_until(r_cyc + 11);
    check("int_low_before_repeat", 32'(int_req), 32'(0));
    step();
    check("int_repeat_12", 32'(int_req), 32'(1));
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    check("int_ack_clears2", 32'(int_req), 32'(0));
    wait_until(r_cyc + 23);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    check("set_beats_ack", 32'(int_req), 32'(1));
    bus_xfer(1'b1, 8'h13, 8'h80, rd, lat);
    check("w1c_clears_int", 32'(int_req), 32'(0));
    bus_xfer(1'b0, 8'h13, 8'h00, rd, lat);
    check("w1c_keeps_enables", 32'(rd), 32'(8'h03));
    bus_xfer(1'b1, 8'h13, 8'h00, rd, lat);
    bus_xfer(1'b1, 8'h13, 8'h80, rd, lat);
    bus_xfer(1'b0, 8'h13, 8'h00, rd, lat);
    check("ctrl_disabled", 32'(rd), 32'(8'h00));

    // reset during WAIT of an OUT write
    req_start(1'b1, 8'h10, 8'h77);
    step();
    rst_n = 1'b0;
    count_acks(4, acks);
    port_if.cyc = 1'b0; port_if.stb = 1'b0;
    rst_n = 1'b1;
    step(); step();
    check("rst_mid_no_ack", 32'(acks), 32'(0));
    check("rst_mid_gpio",   32'(gpio_o), 32'(0));
    bus_xfer(1'b1, 8'h10, 8'h99, rd, lat);
    check("post_rst_lat",  32'(lat), 32'(WS + 1));
    check("post_rst_gpio", 32'(gpio_o), 32'(8'h99));
    bus_xfer(1'b0, 8'h12, 8'h00, rd, lat);
    check("post_rst_reload", 32'(rd), 32'(8'hFF));

    // random register traffic against a simple register model
    m_out = 8'h99; m_reload = 8'hFF; m_in = gpio_i;
    for (int n = 0; n < 60; n++) begin
      d = 8'($urandom);
      case ($urandom_range(0, 6))
        0: begin bus_xfer(1'b1, 8'h10, d, rd, lat); m_out = d; end
        1: begin bus_xfer(1'b1, 8'h12, d, rd, lat); m_reload = d; end
        2: begin bus_xfer(1'b0, 8'h10, 8'h00, rd, lat);
                 check("rnd_out", 32'(rd), 32'(m_out)); end
        3: begin bus_xfer(1'b0, 8'h12, 8'h00, rd, lat);
                 check("rnd_reload", 32'(rd), 32'(m_reload)); end
        4: begin bus_xfer(1'b0, 8'h11, 8'h00, rd, lat);
                 check("rnd_in", 32'(rd), 32'(m_in)); end
        5: begin bus_xfer(1'b1, 8'h11, d, rd, lat); end
        default: begin gpio_i = d; m_in = d; step(); step(); step(); end
      endcase
      check("rnd_gpio", 32'(gpio_o), 32'(m_out));
    end

    check("rd_dat_zero_without_ack", 32'(rd_leak), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
